// File: rtl/stream_sorter_pkg.sv
// sorter_pkg: shared state encoding and counter-width helper for stream_sorter
package sorter_pkg;
  typedef enum logic {FILL, DRAIN} state_t;
  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction
endpackage

// File: rtl/stream_sorter_cell.sv
// sort_cell: one insertion slot; cur/low/din values, occ/low_gt/ins flags in, nxt value and own gt flag out
module sort_cell #(
  parameter int DW = 8
) (
  input  logic [DW-1:0] cur,
  input  logic [DW-1:0] low,
  input  logic [DW-1:0] din,
  input  logic          occ,
  input  logic          low_gt,
  input  logic          ins,
  output logic [DW-1:0] nxt,
  output logic          gt
);
  assign gt = occ && cur > din;
  // slots above the insert point are contiguous, so a greater neighbour below means shift
  assign nxt = !ins ? cur : low_gt ? low : (gt || !occ) ? din : cur;
endmodule

// File: rtl/stream_sorter.sv
// stream_sorter: valid/ready insertion sorter; in_valid/in_ready/in_data/in_last in, out_valid/out_ready/out_data/out_last ascending out
module stream_sorter
  import sorter_pkg::*;
#(
  parameter int N  = 5,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  input  logic          in_last,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic          out_last
);
  localparam int CW = cnt_w(N);
  state_t state;
  logic [CW-1:0] cnt, rd;
  logic [DW-1:0] slot [N];
  logic [DW-1:0] nxt [N];
  logic [DW-1:0] low [N];
  logic [N:0] gt;
  logic acc;
  assign in_ready = state == FILL;
  assign out_valid = state == DRAIN;
  assign acc = in_valid && in_ready;
  assign out_data = slot[rd];
  assign out_last = out_valid && rd == cnt - 1'b1;
  assign gt[0] = 1'b0;
  for (genvar i = 0; i < N; i++) begin : g_cell
    if (i == 0) begin : g_bot
      assign low[i] = '0;
    end else begin : g_up
      assign low[i] = slot[i-1];
    end
    sort_cell #(.DW(DW)) u_cell (
      .cur(slot[i]),
      .low(low[i]),
      .din(in_data),
      .occ(CW'(i) < cnt),
      .low_gt(gt[i]),
      .ins(acc && CW'(i) <= cnt),
      .nxt(nxt[i]),
      .gt(gt[i+1])
    );
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= FILL;
      cnt <= '0;
      rd <= '0;
      for (int k = 0; k < N; k++) slot[k] <= '0;
    end else begin
      slot <= nxt;
      if (acc) begin
        cnt <= cnt + 1'b1;
        if (in_last || cnt + 1'b1 == CW'(N)) begin
          state <= DRAIN;
          rd <= '0;
        end
      end else if (out_valid && out_ready) begin
        if (out_last) begin
          state <= FILL;
          cnt <= '0;
          rd <= '0;
        end else begin
          rd <= rd + 1'b1;
        end
      end
    end
  end
endmodule

// File: doc/stream_sorter.md
# stream_sorter

Sequential insertion sorter that accepts a frame of up to N unsigned DW-bit elements over a valid/ready stream and returns the frame in ascending order over a second valid/ready stream. It is the serial-stream counterpart of the team's combinational parallel sorting network. It sits between a producer that emits elements one at a time and a consumer that reads ranked results one at a time, so no N×DW-wide bus is needed at either end.

## Interface
- `N`, default 5: maximum elements per frame; N ≥ 2.
- `DW`, default 8: element width in bits; compared as unsigned.
- `clk` input, 1 bit: single clock; all logic is rising-edge.
- `rst_n` input, 1 bit: reset, asynchronous, active-low.
- `in_valid` input, 1 bit: producer has an element.
- `in_ready` output, 1 bit: sorter accepts an element this cycle.
- `in_data` input, DW bits: element.
- `in_last` input, 1 bit: final element of the frame; qualified by `in_valid`.
- `out_valid` output, 1 bit: sorted element available.
- `out_ready` input, 1 bit: consumer takes the element.
- `out_data` output, DW bits: current sorted element, smallest first.
- `out_last` output, 1 bit: `out_data` is the final (largest) element of the frame.

## Operation
- Storage: N slots `slot[0..N-1]`, a fill count `cnt` of width $clog2(N+1), a read index `rd`, and a state register.
- Two states:
  - FILL (reset state): `in_ready`=1, `out_valid`=0.
  - DRAIN: `in_ready`=0, `out_valid`=1.
- FILL insertion on each accept (`in_valid && in_ready`), completed in one cycle:
  - Every occupied slot with value > `in_data` shifts up one position.
  - `in_data` is written into the first slot whose value is > `in_data`, or into `slot[cnt]` if no such slot exists.
  - `cnt` increments.
- Ties are stable: a new element equal to stored values is placed after them.
- FILL → DRAIN on an accept with `in_last`=1, or when the accept brings `cnt` to N. Set `rd`=0 on this transition.
- An accept with `in_last`=1 and `cnt`=N-1 is a single transition. It is not an error.
- DRAIN outputs:
  - `out_data` = `slot[rd]`.
  - `out_last` = (`rd` == `cnt`-1).
- On each output handshake `rd` increments. On the handshake with `out_last`=1:
  - state → FILL
  - `cnt` ← 0
  - `rd` ← 0
- Inputs offered during DRAIN are not accepted. They stay pending on the producer side.
- Slot contents are not cleared between frames. Stale data is never output because `cnt` bounds both insertion and drain.

## Timing
- Reset values: `in_ready`=1, `out_valid`=0, `out_data`=0, `out_last`=0, `cnt`=0, `rd`=0, all slots 0, state FILL.
- Reset applies asynchronously. Outputs take reset values immediately, including mid-frame or mid-drain; the partial frame is discarded.
- Latency: if the final element is accepted at edge t, `out_valid`=1 with the smallest element from edge t onward, i.e. in the cycle after the accept.
- Drain throughput is one element per cycle while `out_ready`=1.
- A frame of k elements occupies k accept cycles plus k drain cycles. There is no idle cycle between frames: `in_ready`=1 in the cycle after the last output handshake.
- With `out_ready`=0, `out_data` and `out_last` are held stable.
- All outputs are functions of registers only. There is no combinational path from `in_*` to `out_*`, or from `out_ready` to `in_ready`.

## Structure
- Package `sorter_pkg`:
  - state enum `{FILL, DRAIN}`;
  - helper `cnt_w(N)` = $clog2(N+1).
- Sub-module `sort_cell`, one per slot, parameter DW.
  - Inputs: own value, lower neighbour value, `in_data`, occupied flag, lower-neighbour "greater" flag, insert strobe.
  - Outputs: next value and own "greater" flag.
  - Each cell decides locally among hold, shift-from-below and load-new.
- The top level holds the FSM, `cnt`, `rd` and the output mux.

## Test plan
- Full frame: N=5, DW=8, input 30,10,50,20,40 with `in_last` on 40 → output 10,20,30,40,50; `out_last` only on 50; `in_ready`=0 throughout the drain.
- Duplicates: input 7,3,7,3,7 → output 3,3,7,7,7; `cnt` returns to 0 after the final handshake.
- Short frame and extremes: input 200,0,255 with `in_last` on 255 → output 0,200,255 with `out_last` on 255; a next frame of 5,1 outputs 1,5 with no stale values.
- Backpressure: during the drain, hold `out_ready`=0 for 3 cycles at the second element → `out_data`=20 stable for all 3 cycles; the sequence completes unchanged.
- Reset mid-drain: assert `rst_n`=0 after 2 outputs → `out_valid`=0 and `in_ready`=1 immediately; a frame of 9,8,7,6,5 sent after release outputs 5,6,7,8,9.
- Back-to-back frames: `in_valid` and `out_ready` held at 1, random data across 20 frames of random length 1..5 → each output frame matches a scoreboard sort; `in_ready` rises in the cycle after each `out_last` handshake.
